lpc_cycle_decoder: RTL and testbench
====================================

# lpc_cycle_decoder

Passive LPC bus decoder, parametrised successor of the LPC sniffer core. It reconstructs complete I/O and memory read/write cycles from lpc_ad/lpc_frame, including 1/2/4-byte transfers and arbitrarily long wait-sync sequences. Completed cycles go to the capture/UART path through a single-cycle strobe. Aborted, errored and timed-out cycles are reported on a separate error strobe and never appear on the data strobe.

## Interface
- MAX_BYTES, 4: largest accepted transfer size (1, 2 or 4); cycles declaring more are ignored.
- SYNC_TIMEOUT, 16: maximum consecutive wait-sync nibbles (0101/0110) before the cycle is dropped as timed out.
- CNT_WIDTH, 8: width of the dropped-cycle counter.
- lpc_clock  in  1  LPC clock; all logic on rising edge.
- lpc_reset  in  1  asynchronous, active-low reset.
- lpc_ad  in  4  LPC address/data nibble.
- lpc_frame  in  1  LPC frame, active low.
- out_cyctype_dir  out  4  cycle-type/direction nibble of the reported cycle.
- out_addr  out  32  address; I/O cycles zero-extended from 16 bits.
- out_data  out  32  data, byte 0 in [7:0]; unused upper bytes zero.
- out_data_size  out  3  byte count: 1, 2 or 4.
- out_clock_enable  out  1  one-cycle strobe, outputs valid.
- out_error  out  1  one-cycle strobe, a cycle was dropped.
- out_error_code  out  2  1 = sync error, 2 = sync timeout, 3 = abort. Holds until the next out_error.
- out_drop_count  out  CNT_WIDTH  saturating count of out_error strobes.

## Operation
- States: IDLE, CTDIR, SIZE, ADDR, WDATA, TAR1, TAR2, SYNC, RDATA, SKIP.
- Frame low in any state: latch lpc_ad as the start code. If the state was CTDIR..RDATA, raise out_error with code 3, but only once per frame-low run.
- Frame high after a frame-low run:
  - Start code 0000: the first frame-high cycle is processed as CTDIR.
  - Any other start code: go to IDLE.
- CTDIR:
  - [3:2] = 00 (I/O): size 1, 4 address nibbles, go to ADDR.
  - [3:2] = 01 (memory): go to SIZE, 8 address nibbles.
  - 10 or 11: go to SKIP. SKIP waits for frame low with no report.
  - [1] = 1 means write.
- SIZE (memory cycles only): [1:0]
  - 0 gives 1 byte, 1 gives 2 bytes, 3 gives 4 bytes.
  - 2, or a size > MAX_BYTES, goes to SKIP.
- ADDR: shift nibbles MSB first.
  - Write: go to WDATA.
  - Read: go to TAR1.
- WDATA / RDATA: 2×size nibbles. Within each byte the low nibble comes first; bytes are ordered from byte 0 upward.
- TAR1 → TAR2 → SYNC; TAR nibbles are ignored.
- SYNC nibble handling:
  - 0000, write cycle: report, go to IDLE.
  - 0000, read cycle: go to RDATA; report after the last nibble, then IDLE.
  - 0101 / 0110: stay in SYNC and increment the wait counter. When the counter would exceed SYNC_TIMEOUT, raise error code 2 and go to SKIP.
  - 1010 or any other nibble: error code 1, go to SKIP.
- The trailing TAR after a report is absorbed in IDLE, since frame is high.
- out_drop_count increments on each out_error and saturates at all-ones.

## Timing
- Reset (async, lpc_reset = 0):
  - State is IDLE.
  - All outputs are 0, including out_error_code and out_drop_count.
  - Internal shift registers and the wait counter are cleared.
  - A cycle in progress is discarded without an error report.
- Report latency:
  - out_clock_enable rises in the cycle after the edge that sampled the completing nibble (0000 sync for writes, last data nibble for reads).
  - It is high for exactly one lpc_clock.
  - out_cyctype_dir, out_addr, out_data and out_data_size update on that same edge and hold until the next report.
- out_error rises in the cycle after the edge that sampled the offending nibble or the first frame-low cycle. It is high for one clock.
- The wait counter resets on entry to TAR1. SYNC_TIMEOUT consecutive wait syncs are accepted; wait sync number SYNC_TIMEOUT+1 triggers the timeout.
- A frame-low start code of 0000 sampled in the same cycle as a sync nibble takes priority: the sync is ignored, the abort is reported, and the new cycle begins.
- Back-to-back cycles are supported: a start may follow immediately after the report or the second TAR nibble.

## Test plan
- Memory write, size 1, address 0x12347fe5, data 0x69ce, zero sync:
  - one out_clock_enable;
  - ct_dir 0110, address 0x12347fe5, data 0x000069ce, size 2;
  - no out_error.
- Memory write, size 3, address 0x12347fe4, data 0x69cd, followed by 9 short syncs, an abort (frame low 4 clocks, ad = 1111), then the previous scenario:
  - one out_error with code 3;
  - out_drop_count = 1;
  - exactly one report, identical to the first scenario.
- I/O read, address 0x0080, ad 0000 → 0000, TAR, 0000 sync, data 0x5a:
  - ct_dir 0000, address 0x00000080, data 0x0000005a, size 1.
- Memory read, 17 long-wait syncs with SYNC_TIMEOUT = 16:
  - out_error code 2 on the 17th wait sync;
  - no report;
  - a following I/O write reports normally.
- Sync 1010 on an I/O write: out_error code 1, no report.
- Assert lpc_reset mid-ADDR of a memory write:
  - all outputs 0 immediately;
  - no strobe;
  - the next full cycle reports correctly.

Source files
------------

// File: rtl/lpc_cycle_decoder.sv
// Passive LPC cycle decoder. Rebuilds I/O and memory read/write cycles from
// lpc_ad/lpc_frame and reports each completed cycle with a one-clock strobe.
// Dropped cycles (sync error, sync timeout, abort) go to a separate error
// strobe with a code and a saturating drop counter.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no cycle in progress, waiting for frame low
// CTDIR | cycle-type/direction nibble
// SIZE  | memory size nibble
// ADDR  | address nibbles, MSB first
// WDATA | write data nibbles, low nibble of byte 0 first
// TAR1  | first turnaround nibble
// TAR2  | second turnaround nibble
// SYNC  | sync nibbles, wait syncs counted against the timeout
// RDATA | read data nibbles, low nibble of byte 0 first
// SKIP  | unsupported or dropped cycle, waiting for frame low
module lpc_cycle_decoder #(
    parameter int MAX_BYTES    = 4,
    parameter int SYNC_TIMEOUT = 16,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                 lpc_clock,
    input  logic                 lpc_reset,
    input  logic [3:0]           lpc_ad,
    input  logic                 lpc_frame,
    output logic [3:0]           out_cyctype_dir,
    output logic [31:0]          out_addr,
    output logic [31:0]          out_data,
    output logic [2:0]           out_data_size,
    output logic                 out_clock_enable,
    output logic                 out_error,
    output logic [1:0]           out_error_code,
    output logic [CNT_WIDTH-1:0] out_drop_count
);

    localparam int WAIT_W = $clog2(SYNC_TIMEOUT + 1);

    typedef enum logic [3:0] {
        IDLE, CTDIR, SIZE, ADDR, WDATA, TAR1, TAR2, SYNC, RDATA, SKIP
    } state_t;

    state_t            state, state_d, cur;
    logic              low_q;
    logic [3:0]        start_code, start_code_d;
    logic [3:0]        ctdir, ctdir_d;
    logic              is_write, is_write_d;
    logic [2:0]        size, size_d, sz;
    logic [31:0]       addr, addr_d;
    logic [31:0]       data, data_d;
    logic [3:0]        cnt, cnt_d;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_d;
    logic              report, err;
    logic [1:0]        err_code;
    logic [3:0]        last_nib;

    // Index of the final data nibble: two nibbles per byte.
    assign last_nib = {size, 1'b0} - 4'd1;

    // Next-state, datapath and strobe decode.
    always_comb begin
        state_d      = state;
        start_code_d = start_code;
        ctdir_d      = ctdir;
        is_write_d   = is_write;
        size_d       = size;
        addr_d       = addr;
        data_d       = data;
        cnt_d        = cnt;
        wait_cnt_d   = wait_cnt;
        report       = 1'b0;
        err          = 1'b0;
        err_code     = 2'd0;
        sz           = 3'd0;
        cur          = state;

        if (!lpc_frame) begin
            // A new frame always wins; only the first low cycle can abort.
            start_code_d = lpc_ad;
            state_d      = IDLE;
            if (!low_q && state != IDLE && state != SKIP) begin
                err      = 1'b1;
                err_code = 2'd3;
            end
        end else begin
            // First high cycle after a frame-low run carries the CTDIR nibble.
            if (low_q) begin
                cur = (start_code == 4'd0) ? CTDIR : IDLE;
            end
            case (cur)
                IDLE: state_d = IDLE;
                SKIP: state_d = SKIP;
                CTDIR: begin
                    ctdir_d    = lpc_ad;
                    is_write_d = lpc_ad[1];
                    addr_d     = 32'd0;
                    data_d     = 32'd0;
                    case (lpc_ad[3:2])
                        2'b00: begin
                            size_d  = 3'd1;
                            cnt_d   = 4'd3;
                            state_d = ADDR;
                        end
                        2'b01: begin
                            cnt_d   = 4'd7;
                            state_d = SIZE;
                        end
                        default: state_d = SKIP;
                    endcase
                end
                SIZE: begin
                    case (lpc_ad[1:0])
                        2'd0:    sz = 3'd1;
                        2'd1:    sz = 3'd2;
                        2'd3:    sz = 3'd4;
                        default: sz = 3'd0;
                    endcase
                    if (sz == 3'd0 || int'(sz) > MAX_BYTES) begin
                        state_d = SKIP;
                    end else begin
                        size_d  = sz;
                        state_d = ADDR;
                    end
                end
                ADDR: begin
                    addr_d = {addr[27:0], lpc_ad};
                    if (cnt == 4'd0) begin
                        if (is_write) begin
                            state_d = WDATA;
                        end else begin
                            wait_cnt_d = '0;
                            state_d    = TAR1;
                        end
                    end else begin
                        cnt_d = cnt - 4'd1;
                    end
                end
                WDATA: begin
                    data_d[{cnt[2:0], 2'b00} +: 4] = lpc_ad;
                    if (cnt == last_nib) begin
                        wait_cnt_d = '0;
                        state_d    = TAR1;
                    end else begin
                        cnt_d = cnt + 4'd1;
                    end
                end
                TAR1: state_d = TAR2;
                TAR2: state_d = SYNC;
                SYNC: begin
                    case (lpc_ad)
                        4'b0000: begin
                            if (is_write) begin
                                report  = 1'b1;
                                state_d = IDLE;
                            end else begin
                                cnt_d   = 4'd0;
                                state_d = RDATA;
                            end
                        end
                        4'b0101, 4'b0110: begin
                            if (wait_cnt == WAIT_W'(SYNC_TIMEOUT)) begin
                                err      = 1'b1;
                                err_code = 2'd2;
                                state_d  = SKIP;
                            end else begin
                                wait_cnt_d = wait_cnt + WAIT_W'(1);
                            end
                        end
                        default: begin
                            err      = 1'b1;
                            err_code = 2'd1;
                            state_d  = SKIP;
                        end
                    endcase
                end
                RDATA: begin
                    data_d[{cnt[2:0], 2'b00} +: 4] = lpc_ad;
                    if (cnt == last_nib) begin
                        report  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt + 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            state            <= IDLE;
            low_q            <= 1'b0;
            start_code       <= 4'd0;
            ctdir            <= 4'd0;
            is_write         <= 1'b0;
            size             <= 3'd0;
            addr             <= 32'd0;
            data             <= 32'd0;
            cnt              <= 4'd0;
            wait_cnt         <= '0;
            out_cyctype_dir  <= 4'd0;
            out_addr         <= 32'd0;
            out_data         <= 32'd0;
            out_data_size    <= 3'd0;
            out_clock_enable <= 1'b0;
            out_error        <= 1'b0;
            out_error_code   <= 2'd0;
            out_drop_count   <= '0;
        end else begin
            state            <= state_d;
            low_q            <= !lpc_frame;
            start_code       <= start_code_d;
            ctdir            <= ctdir_d;
            is_write         <= is_write_d;
            size             <= size_d;
            addr             <= addr_d;
            data             <= data_d;
            cnt              <= cnt_d;
            wait_cnt         <= wait_cnt_d;
            out_clock_enable <= report;
            out_error        <= err;
            if (report) begin
                out_cyctype_dir <= ctdir;
                out_addr        <= addr;
                out_data        <= data_d;
                out_data_size   <= size;
            end
            if (err) begin
                out_error_code <= err_code;
                if (out_drop_count != '1) begin
                    out_drop_count <= out_drop_count + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_lpc_cycle_decoder.sv
// Directed bench for lpc_cycle_decoder: drives LPC nibbles on the falling
// edge and checks outputs shortly after the following falling edge.
module tb_lpc_cycle_decoder;

    logic        lpc_clock;
    logic        lpc_reset;
    logic [3:0]  lpc_ad;
    logic        lpc_frame;
    logic [3:0]  out_cyctype_dir;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [2:0]  out_data_size;
    logic        out_clock_enable;
    logic        out_error;
    logic [1:0]  out_error_code;
    logic [7:0]  out_drop_count;

    int n_cmp = 0;
    int n_bad = 0;
    int ce_cnt = 0;
    int err_cnt = 0;
    int ce0;
    int err0;

    lpc_cycle_decoder #(.MAX_BYTES(4), .SYNC_TIMEOUT(16), .CNT_WIDTH(8)) dut (
        .lpc_clock       (lpc_clock),
        .lpc_reset       (lpc_reset),
        .lpc_ad          (lpc_ad),
        .lpc_frame       (lpc_frame),
        .out_cyctype_dir (out_cyctype_dir),
        .out_addr        (out_addr),
        .out_data        (out_data),
        .out_data_size   (out_data_size),
        .out_clock_enable(out_clock_enable),
        .out_error       (out_error),
        .out_error_code  (out_error_code),
        .out_drop_count  (out_drop_count)
    );

    initial lpc_clock = 1'b0;
    always #5 lpc_clock = ~lpc_clock;

    // Strobe counters, sampled on the falling edge.
    always @(negedge lpc_clock) begin
        if (out_clock_enable) ce_cnt = ce_cnt + 1;
        if (out_error) err_cnt = err_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nib(input logic f, input logic [3:0] a);
        @(negedge lpc_clock);
        lpc_frame = f;
        lpc_ad    = a;
    endtask

    task automatic send(input logic [3:0] a);
        nib(1'b1, a);
    endtask

    task automatic send_addr(input logic [31:0] a, input int n);
        for (int i = n - 1; i >= 0; i--) send(a[4*i +: 4]);
    endtask

    task automatic send_data(input logic [31:0] d, input int nbytes);
        for (int i = 0; i < 2 * nbytes; i++) send(d[4*i +: 4]);
    endtask

    task automatic check_report(input string tag, input logic [3:0] ct, input logic [31:0] a,
                                input logic [31:0] d, input logic [2:0] s);
        check({tag, "_ct"}, out_cyctype_dir, ct);
        check({tag, "_addr"}, out_addr, a);
        check({tag, "_data"}, out_data, d);
        check({tag, "_size"}, out_data_size, s);
    endtask

    // Memory write, 2 bytes, 0x12347fe5 <- 0x69ce, zero-wait sync.
    task automatic mem_write_s1();
        nib(1'b0, 4'h0);
        send(4'b0110);
        send(4'b0001);
        send_addr(32'h12347fe5, 8);
        send_data(32'h000069ce, 2);
        send(4'hf);
        send(4'hf);
        send(4'h0);
    endtask

    initial begin
        lpc_reset = 1'b1;
        lpc_frame = 1'b1;
        lpc_ad    = 4'hf;
        #3 lpc_reset = 1'b0;
        #1;
        check("rst_ce", out_clock_enable, 0);
        check("rst_err", out_error, 0);
        check("rst_code", out_error_code, 0);
        check("rst_drop", out_drop_count, 0);
        check("rst_addr", out_addr, 0);
        check("rst_data", out_data, 0);
        repeat (2) @(negedge lpc_clock);
        lpc_reset = 1'b1;

        // Scenario 1: memory write, latency and single-cycle strobe.
        ce0 = ce_cnt; err0 = err_cnt;
        mem_write_s1();
        send(4'hf); #1;
        check("s1_ce_rise", out_clock_enable, 1);
        send(4'hf); #1;
        check("s1_ce_fall", out_clock_enable, 0);
        check_report("s1", 4'b0110, 32'h12347fe5, 32'h000069ce, 3'd2);
        check("s1_ce_count", ce_cnt - ce0, 1);
        check("s1_err_count", err_cnt - err0, 0);

        // Scenario 2: 4-byte write, 9 waits, abort, then scenario 1 again.
        ce0 = ce_cnt; err0 = err_cnt;
        nib(1'b0, 4'h0);
        send(4'b0110);
        send(4'b0011);
        send_addr(32'h12347fe4, 8);
        send_data(32'h000069cd, 4);
        send(4'hf);
        send(4'hf);
        repeat (9) send(4'b0101);
        repeat (4) nib(1'b0, 4'hf);
        send(4'hf); #1;
        check("s2_err_count", err_cnt - err0, 1);
        check("s2_code", out_error_code, 3);
        check("s2_drop", out_drop_count, 1);
        check("s2_no_report", ce_cnt - ce0, 0);
        mem_write_s1();
        send(4'hf);
        send(4'hf); #1;
        check("s2_ce_count", ce_cnt - ce0, 1);
        check("s2_err_total", err_cnt - err0, 1);
        check_report("s2", 4'b0110, 32'h12347fe5, 32'h000069ce, 3'd2);

        // Scenario 3: I/O read of 0x0080, data 0x5a.
        ce0 = ce_cnt; err0 = err_cnt;
        nib(1'b0, 4'h0);
        send(4'b0000);
        send_addr(32'h00000080, 4);
        send(4'hf);
        send(4'hf);
        send(4'h0);
        send_data(32'h0000005a, 1);
        send(4'hf); #1;
        check("s3_ce_rise", out_clock_enable, 1);
        send(4'hf); #1;
        check_report("s3", 4'b0000, 32'h00000080, 32'h0000005a, 3'd1);
        check("s3_ce_count", ce_cnt - ce0, 1);
        check("s3_err_count", err_cnt - err0, 0);

        // Scenario 4: memory read with 17 long waits times out.
        ce0 = ce_cnt; err0 = err_cnt;
        nib(1'b0, 4'h0);
        send(4'b0100);
        send(4'b0000);
        send_addr(32'hfed00010, 8);
        send(4'hf);
        send(4'hf);
        repeat (16) send(4'b0110);
        send(4'b0110); #1;
        check("s4_16_waits_ok", err_cnt - err0, 0);
        send(4'hf); #1;
        check("s4_err_strobe", out_error, 1);
        check("s4_code", out_error_code, 2);
        repeat (3) send(4'hf);
        check("s4_no_report", ce_cnt - ce0, 0);
        check("s4_drop", out_drop_count, 2);
        // Following I/O write of 0xa5 to 0x0080.
        nib(1'b0, 4'h0);
        send(4'b0010);
        send_addr(32'h00000080, 4);
        send_data(32'h000000a5, 1);
        send(4'hf);
        send(4'hf);
        send(4'h0);
        send(4'hf);
        send(4'hf); #1;
        check("s4_ce_count", ce_cnt - ce0, 1);
        check_report("s4", 4'b0010, 32'h00000080, 32'h000000a5, 3'd1);

        // Scenario 5: I/O write with a 1010 sync, then an illegal size.
        ce0 = ce_cnt; err0 = err_cnt;
        nib(1'b0, 4'h0);
        send(4'b0010);
        send_addr(32'h00000060, 4);
        send_data(32'h00000033, 1);
        send(4'hf);
        send(4'hf);
        send(4'b1010);
        send(4'hf); #1;
        check("s5_err_strobe", out_error, 1);
        check("s5_code", out_error_code, 1);
        nib(1'b0, 4'h0);
        send(4'b0110);
        send(4'b0010);
        repeat (14) send(4'h0);
        send(4'hf); #1;
        check("s5_no_report", ce_cnt - ce0, 0);
        check("s5_err_count", err_cnt - err0, 1);
        check("s5_drop", out_drop_count, 3);

        // Scenario 6: reset in the middle of an address phase.
        ce0 = ce_cnt; err0 = err_cnt;
        nib(1'b0, 4'h0);
        send(4'b0110);
        send(4'b0000);
        send(4'ha);
        send(4'hb);
        send(4'hc);
        @(negedge lpc_clock);
        #2 lpc_reset = 1'b0;
        #1;
        check("s6_rst_ct", out_cyctype_dir, 0);
        check("s6_rst_addr", out_addr, 0);
        check("s6_rst_data", out_data, 0);
        check("s6_rst_size", out_data_size, 0);
        check("s6_rst_code", out_error_code, 0);
        check("s6_rst_drop", out_drop_count, 0);
        send(4'hd);
        send(4'h0);
        @(negedge lpc_clock);
        lpc_reset = 1'b1;
        send(4'h1);
        send(4'hf); #1;
        check("s6_no_strobe", (ce_cnt - ce0) + (err_cnt - err0), 0);
        nib(1'b0, 4'h0);
        send(4'b0110);
        send(4'b0000);
        send_addr(32'habcd0123, 8);
        send_data(32'h00000077, 1);
        send(4'hf);
        send(4'hf);
        send(4'h0);
        send(4'hf);
        send(4'hf); #1;
        check("s6_ce_count", ce_cnt - ce0, 1);
        check_report("s6", 4'b0110, 32'habcd0123, 32'h00000077, 3'd1);
        check("s6_drop", out_drop_count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
